// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared types for the back-end memory fault pipeline.
// Holds the access size encoding, the memory exception cause codes,
// the privilege mode encoding and a small alignment helper.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_size_b = 2'd0,
    e_size_h = 2'd1,
    e_size_w = 2'd2,
    e_size_d = 2'd3
  } bp_be_size_e;

  typedef enum logic [3:0] {
    e_cause_none             = 4'd0,
    e_cause_load_misaligned  = 4'd4,
    e_cause_load_access      = 4'd5,
    e_cause_store_misaligned = 4'd6,
    e_cause_store_access     = 4'd7,
    e_cause_load_page        = 4'd13,
    e_cause_store_page       = 4'd15
  } bp_be_mem_cause_e;

  typedef enum logic [1:0] {
    e_priv_user    = 2'd0,
    e_priv_super   = 2'd1,
    e_priv_reserve = 2'd2,
    e_priv_machine = 2'd3
  } bp_be_priv_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input bp_be_size_e size, input logic [2:0] addr_lo);
    logic mis;
    case (size)
      e_size_b: mis = 1'b0;
      e_size_h: mis = addr_lo[0];
      e_size_w: mis = |addr_lo[1:0];
      e_size_d: mis = |addr_lo[2:0];
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/bp_be_mem_fault_capture.sv
// bp_be_mem_fault_capture: first-fault capture register.
// Latches the cause and vaddr of the first reported exception and holds
// them until software clears it; a fault arriving with the clear wins.
module bp_be_mem_fault_capture #(
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     exc_v_i,
  input  logic [3:0]               cause_i,
  input  logic [vaddr_width_p-1:0] vaddr_i,
  input  logic                     clr_i,
  output logic                     capture_v_o,
  output logic [3:0]               capture_cause_o,
  output logic [vaddr_width_p-1:0] capture_vaddr_o
);

  logic                     cap_v_q, cap_v_d;
  logic [3:0]               cap_cause_q, cap_cause_d;
  logic [vaddr_width_p-1:0] cap_vaddr_q, cap_vaddr_d;
  logic                     load_s;

  // A slot is free when empty or being cleared this same cycle.
  assign load_s = v_i & exc_v_i & (~cap_v_q | clr_i);

  // Next-state: load has priority over clear, otherwise hold.
  always_comb begin
    cap_v_d     = cap_v_q;
    cap_cause_d = cap_cause_q;
    cap_vaddr_d = cap_vaddr_q;
    if (load_s) begin
      cap_v_d     = 1'b1;
      cap_cause_d = cause_i;
      cap_vaddr_d = vaddr_i;
    end else if (clr_i) begin
      cap_v_d = 1'b0;
    end else begin
      cap_v_d = cap_v_q;
    end
  end

  // Capture state register with asynchronous clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cap_v_q     <= 1'b0;
      cap_cause_q <= 4'd0;
      cap_vaddr_q <= '0;
    end else begin
      cap_v_q     <= cap_v_d;
      cap_cause_q <= cap_cause_d;
      cap_vaddr_q <= cap_vaddr_d;
    end
  end

  assign capture_v_o     = cap_v_q;
  assign capture_cause_o = cap_cause_q;
  assign capture_vaddr_o = cap_vaddr_q;

endmodule

// File: rtl/bp_be_mem_fault_pipe.sv
// bp_be_mem_fault_pipe: memory fault evaluation pipeline.
// Faults are computed combinationally on the incoming request and carried
// through a stages_p-deep register pipeline; the last stage drives the
// outputs. Invalid stages are kept all-zero so no stale cause leaks out.
// Optional feature: define BP_BE_MISALIGNED_TRAP_EN to enable misaligned
// traps (causes 4/6); without it, misaligned accesses are never flagged.
module bp_be_mem_fault_pipe
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int eaddr_width_p = 64,
  parameter int stages_p      = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     flush_i,
  input  logic                     stall_i,
  input  logic                     v_i,
  input  logic                     store_i,
  input  logic [1:0]               size_i,
  input  logic [eaddr_width_p-1:0] eaddr_i,
  input  logic                     translation_en_i,
  input  logic [1:0]               priv_mode_i,
  input  logic                     mstatus_sum_i,
  input  logic                     tlb_v_i,
  input  logic                     tlb_u_i,
  input  logic                     tlb_w_i,
  input  logic                     tlb_d_i,
  input  logic                     access_fault_i,
  output logic                     v_o,
  output logic [vaddr_width_p-1:0] vaddr_o,
  output logic                     exc_v_o,
  output logic [3:0]               exc_cause_o,
  output logic                     tlb_miss_v_o,
  output logic                     capture_v_o,
  output logic [3:0]               capture_cause_o,
  output logic [vaddr_width_p-1:0] capture_vaddr_o,
  input  logic                     capture_clr_i
);

  localparam int hi_width_lp = eaddr_width_p - vaddr_width_p;

  typedef struct packed {
    logic                     v;
    logic [vaddr_width_p-1:0] vaddr;
    logic                     exc_v;
    logic [3:0]               cause;
    logic                     tlb_miss;
  } stage_t;

  stage_t stage_q [stages_p];
  stage_t stage_d [stages_p];
  stage_t entry_s;

  logic             noncanon_s;
  logic             misaligned_s;
  logic             priv_fault_s;
  logic             perm_fault_s;
  logic             page_fault_s;
  logic             access_fault_s;
  logic             exc_s;
  logic             tlb_miss_s;
  bp_be_mem_cause_e cause_s;

  // Upper bits must replicate the top vaddr bit.
  assign noncanon_s = (eaddr_i[eaddr_width_p-1:vaddr_width_p]
                       != {hi_width_lp{eaddr_i[vaddr_width_p-1]}});

`ifdef BP_BE_MISALIGNED_TRAP_EN
  assign misaligned_s = is_misaligned(bp_be_size_e'(size_i), eaddr_i[2:0]);
`else
  logic unused_size_s;
  assign unused_size_s = ^size_i;
  assign misaligned_s  = 1'b0;
`endif

  // S mode touching user pages without SUM, or U mode touching supervisor pages.
  assign priv_fault_s = ((priv_mode_i == e_priv_super) & ~mstatus_sum_i & tlb_u_i)
                      | ((priv_mode_i == e_priv_user) & ~tlb_u_i);
  assign perm_fault_s = store_i & (~tlb_w_i | ~tlb_d_i);

  // Non-canonical addresses are page faults under translation, access faults without.
  assign page_fault_s   = translation_en_i
                        & (noncanon_s | (tlb_v_i & (priv_fault_s | perm_fault_s)));
  assign access_fault_s = (~translation_en_i & noncanon_s)
                        | (access_fault_i & (tlb_v_i | ~translation_en_i));

  // A miss only exists for well-formed translated requests; it never overlaps a fault.
  assign tlb_miss_s = translation_en_i & ~tlb_v_i & ~misaligned_s & ~noncanon_s;

  assign exc_s = misaligned_s | page_fault_s | access_fault_s;

  // Cause selection with misaligned > page > access priority.
  always_comb begin
    cause_s = e_cause_none;
    if (misaligned_s) begin
      cause_s = store_i ? e_cause_store_misaligned : e_cause_load_misaligned;
    end else if (page_fault_s) begin
      cause_s = store_i ? e_cause_store_page : e_cause_load_page;
    end else if (access_fault_s) begin
      cause_s = store_i ? e_cause_store_access : e_cause_load_access;
    end else begin
      cause_s = e_cause_none;
    end
  end

  // Build the stage-1 entry; an idle slot is all zeros.
  always_comb begin
    entry_s = '0;
    if (v_i) begin
      entry_s.v        = 1'b1;
      entry_s.vaddr    = eaddr_i[vaddr_width_p-1:0];
      entry_s.exc_v    = exc_s;
      entry_s.cause    = cause_s;
      entry_s.tlb_miss = tlb_miss_s;
    end else begin
      entry_s = '0;
    end
  end

  // Pipeline advance: flush clears everything and beats stall; stall holds.
  always_comb begin
    for (int i = 0; i < stages_p; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (flush_i) begin
      for (int i = 0; i < stages_p; i++) begin
        stage_d[i] = '0;
      end
    end else if (stall_i) begin
      for (int i = 0; i < stages_p; i++) begin
        stage_d[i] = stage_q[i];
      end
    end else begin
      stage_d[0] = entry_s;
      for (int i = 1; i < stages_p; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  // Stage registers; reset drops anything in flight.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < stages_p; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < stages_p; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign v_o          = stage_q[stages_p-1].v;
  assign vaddr_o      = stage_q[stages_p-1].vaddr;
  assign exc_v_o      = stage_q[stages_p-1].exc_v;
  assign exc_cause_o  = stage_q[stages_p-1].cause;
  assign tlb_miss_v_o = stage_q[stages_p-1].tlb_miss;

  bp_be_mem_fault_capture #(
    .vaddr_width_p(vaddr_width_p)
  ) u_capture (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .v_i            (v_o),
    .exc_v_i        (exc_v_o),
    .cause_i        (exc_cause_o),
    .vaddr_i        (vaddr_o),
    .clr_i          (capture_clr_i),
    .capture_v_o    (capture_v_o),
    .capture_cause_o(capture_cause_o),
    .capture_vaddr_o(capture_vaddr_o)
  );

endmodule

// File: tb/tb_bp_be_mem_fault_pipe.sv
// Self-checking bench for bp_be_mem_fault_pipe: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_bp_be_mem_fault_pipe;

  localparam int VW  = 39;
  localparam int EW  = 64;
  localparam int STG = 2;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          flush_i, stall_i, v_i, store_i;
  logic [1:0]    size_i;
  logic [EW-1:0] eaddr_i;
  logic          translation_en_i;
  logic [1:0]    priv_mode_i;
  logic          mstatus_sum_i, tlb_v_i, tlb_u_i, tlb_w_i, tlb_d_i, access_fault_i;
  logic          v_o, exc_v_o, tlb_miss_v_o, capture_v_o, capture_clr_i;
  logic [VW-1:0] vaddr_o, capture_vaddr_o;
  logic [3:0]    exc_cause_o, capture_cause_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_be_mem_fault_pipe #(
    .vaddr_width_p(VW), .eaddr_width_p(EW), .stages_p(STG)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .flush_i(flush_i), .stall_i(stall_i),
    .v_i(v_i), .store_i(store_i), .size_i(size_i), .eaddr_i(eaddr_i),
    .translation_en_i(translation_en_i), .priv_mode_i(priv_mode_i),
    .mstatus_sum_i(mstatus_sum_i), .tlb_v_i(tlb_v_i), .tlb_u_i(tlb_u_i),
    .tlb_w_i(tlb_w_i), .tlb_d_i(tlb_d_i), .access_fault_i(access_fault_i),
    .v_o(v_o), .vaddr_o(vaddr_o), .exc_v_o(exc_v_o), .exc_cause_o(exc_cause_o),
    .tlb_miss_v_o(tlb_miss_v_o), .capture_v_o(capture_v_o),
    .capture_cause_o(capture_cause_o), .capture_vaddr_o(capture_vaddr_o),
    .capture_clr_i(capture_clr_i)
  );

  // Reference model state: requests in flight with the number of edges they advanced.
  typedef struct {
    logic [VW-1:0] va;
    logic          exc;
    logic [3:0]    cause;
    logic          miss;
    int            age;
  } inflight_t;

  inflight_t     q[$];
  logic          m_cap_v;
  logic [3:0]    m_cap_cause;
  logic [VW-1:0] m_cap_va;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Fault classification straight from the architectural rules.
  function automatic void ref_eval(output logic exc, output logic [3:0] cause, output logic miss);
    logic canon, mis, page, acc, priv_f;
    int   bytes;
    canon = (eaddr_i == {{(EW-VW){eaddr_i[VW-1]}}, eaddr_i[VW-1:0]});
    bytes = 1 << size_i;
`ifdef BP_BE_MISALIGNED_TRAP_EN
    mis = ((eaddr_i % bytes) != 0);
`else
    mis = 1'b0;
`endif
    priv_f = (priv_mode_i == 2'd1 && !mstatus_sum_i && tlb_u_i)
          || (priv_mode_i == 2'd0 && !tlb_u_i);
    page = translation_en_i
        && (!canon || (tlb_v_i && (priv_f || (store_i && (!tlb_w_i || !tlb_d_i)))));
    acc  = (!translation_en_i && !canon) || (access_fault_i && (tlb_v_i || !translation_en_i));
    if (mis)       cause = store_i ? 4'd6 : 4'd4;
    else if (page) cause = store_i ? 4'd15 : 4'd13;
    else if (acc)  cause = store_i ? 4'd7 : 4'd5;
    else           cause = 4'd0;
    exc  = mis || page || acc;
    miss = translation_en_i && !tlb_v_i && !mis && canon;
  endfunction

  function automatic void exp_out(output logic ev, output logic [VW-1:0] eva,
                                  output logic eexc, output logic [3:0] ec, output logic emiss);
    ev = 1'b0; eva = '0; eexc = 1'b0; ec = 4'd0; emiss = 1'b0;
    if (q.size() > 0 && q[0].age == STG) begin
      ev = 1'b1; eva = q[0].va; eexc = q[0].exc; ec = q[0].cause; emiss = q[0].miss;
    end
  endfunction

  task automatic compare_all();
    logic ev, eexc, emiss;
    logic [VW-1:0] eva;
    logic [3:0] ec;
    exp_out(ev, eva, eexc, ec, emiss);
    check_val("v_o", v_o, ev);
    check_val("vaddr_o", vaddr_o, eva);
    check_val("exc_v_o", exc_v_o, eexc);
    check_val("exc_cause_o", exc_cause_o, ec);
    check_val("tlb_miss_v_o", tlb_miss_v_o, emiss);
    check_val("capture_v_o", capture_v_o, m_cap_v);
    check_val("capture_cause_o", capture_cause_o, m_cap_cause);
    check_val("capture_vaddr_o", capture_vaddr_o, m_cap_va);
  endtask

  task automatic model_reset();
    q.delete();
    m_cap_v = 1'b0; m_cap_cause = 4'd0; m_cap_va = '0;
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare.
  task automatic cycle();
    logic ev, eexc, emiss;
    logic [VW-1:0] eva;
    logic [3:0] ec;
    inflight_t e;
    exp_out(ev, eva, eexc, ec, emiss);
    @(posedge clk);
    if (ev && eexc && (!m_cap_v || capture_clr_i)) begin
      m_cap_v = 1'b1; m_cap_cause = ec; m_cap_va = eva;
    end else if (capture_clr_i) begin
      m_cap_v = 1'b0;
    end
    if (flush_i) begin
      q.delete();
    end else if (!stall_i) begin
      foreach (q[i]) q[i].age++;
      if (v_i) begin
        ref_eval(e.exc, e.cause, e.miss);
        e.va  = eaddr_i[VW-1:0];
        e.age = 1;
        q.push_back(e);
      end
      while (q.size() > 0 && q[0].age > STG) void'(q.pop_front());
    end
    #1;
    compare_all();
  endtask

  task automatic set_req(input logic v, input logic st, input logic [1:0] sz,
                         input logic [63:0] ea, input logic tr, input logic [1:0] pm,
                         input logic sum, input logic tv, input logic tu,
                         input logic tw, input logic td, input logic af);
    v_i = v; store_i = st; size_i = sz; eaddr_i = ea; translation_en_i = tr;
    priv_mode_i = pm; mstatus_sum_i = sum; tlb_v_i = tv; tlb_u_i = tu;
    tlb_w_i = tw; tlb_d_i = td; access_fault_i = af;
  endtask

  task automatic rand_req();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: eaddr_i = 64'($urandom_range(0, 255));
      1: eaddr_i = {{(EW-VW){r[VW-1]}}, r[VW-1:0]};
      2: eaddr_i = r;
      default: eaddr_i = {{(EW-VW){r[VW-1]}}, r[VW-1:0]} ^ (64'd1 << $urandom_range(VW, EW-1));
    endcase
    v_i              = ($urandom_range(0, 9) < 6);
    store_i          = 1'($urandom_range(0, 1));
    size_i           = 2'($urandom_range(0, 3));
    translation_en_i = ($urandom_range(0, 3) != 0);
    priv_mode_i      = 2'($urandom_range(0, 3));
    mstatus_sum_i    = 1'($urandom_range(0, 1));
    tlb_v_i          = ($urandom_range(0, 3) != 0);
    tlb_u_i          = 1'($urandom_range(0, 1));
    tlb_w_i          = ($urandom_range(0, 3) != 0);
    tlb_d_i          = ($urandom_range(0, 3) != 0);
    access_fault_i   = ($urandom_range(0, 4) == 0);
    stall_i          = ($urandom_range(0, 99) < 15);
    flush_i          = ($urandom_range(0, 99) < 5);
    capture_clr_i    = ($urandom_range(0, 99) < 10);
  endtask

  initial begin
    reset_n_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0; capture_clr_i = 1'b0;
    set_req(1'b0, 1'b0, 2'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset_n_i = 1'b1;

    // U mode load D at 0x1000 with a user page: clean result two cycles later.
    set_req(1'b1, 1'b0, 2'd3, 64'h1000, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(); v_i = 1'b0;
    check_val("lat_not_early", v_o, 1'b0);
    cycle();
    check_val("lat_v", v_o, 1'b1);
    check_val("lat_exc", exc_v_o, 1'b0);
    check_val("lat_vaddr", vaddr_o, 64'h1000);

    // Misaligned store W at 0x1002.
    set_req(1'b1, 1'b1, 2'd2, 64'h1002, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(); v_i = 1'b0; cycle();
`ifdef BP_BE_MISALIGNED_TRAP_EN
    check_val("misal_exc", exc_v_o, 1'b1);
    check_val("misal_cause", exc_cause_o, 4'd6);
`else
    check_val("misal_exc", exc_v_o, 1'b0);
    check_val("misal_cause", exc_cause_o, 4'd0);
`endif

    // Non-canonical load with and without translation.
    set_req(1'b1, 1'b0, 2'd0, 64'h0000_0080_0000_0000, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(); v_i = 1'b0; cycle();
    check_val("noncanon_tr_cause", exc_cause_o, 4'd13);
    set_req(1'b1, 1'b0, 2'd0, 64'h0000_0080_0000_0000, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(); v_i = 1'b0; cycle();
    check_val("noncanon_notr_cause", exc_cause_o, 4'd5);

    // S-mode store to clean page is a page fault, even with an access fault present.
    set_req(1'b1, 1'b1, 2'd3, 64'h2000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(); v_i = 1'b0; cycle();
    check_val("dirty_cause", exc_cause_o, 4'd15);
    set_req(1'b1, 1'b1, 2'd3, 64'h2000, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(); v_i = 1'b0; cycle();
    check_val("prio_cause", exc_cause_o, 4'd15);

    // Empty the capture register.
    repeat (2) cycle();
    capture_clr_i = 1'b1; cycle(); capture_clr_i = 1'b0;
    check_val("cap_cleared", capture_v_o, 1'b0);

    // Two back-to-back faults: first one sticks.
    set_req(1'b1, 1'b0, 2'd0, 64'h111, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle();
    eaddr_i = 64'h222;
    cycle(); v_i = 1'b0;
    repeat (2) cycle();
    check_val("cap_first_v", capture_v_o, 1'b1);
    check_val("cap_first_va", capture_vaddr_o, 64'h111);
    check_val("cap_first_cause", capture_cause_o, 4'd5);
    // Third fault arrives together with the clear and wins.
    v_i = 1'b1; eaddr_i = 64'h333;
    cycle(); v_i = 1'b0;
    cycle();
    capture_clr_i = 1'b1; cycle(); capture_clr_i = 1'b0;
    check_val("cap_third_va", capture_vaddr_o, 64'h333);
    check_val("cap_third_v", capture_v_o, 1'b1);

    // Flush under stall kills the accepted request.
    set_req(1'b1, 1'b0, 2'd0, 64'h444, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    v_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    stall_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_val("flush_no_v", v_o, 1'b0);
    end

    // Reset pulse mid-flight clears everything immediately.
    set_req(1'b1, 1'b0, 2'd0, 64'h555, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(); cycle();
    check_val("pre_rst_v", v_o, 1'b1);
    #2 reset_n_i = 1'b0;
    model_reset();
    #1;
    check_val("rst_v", v_o, 1'b0);
    check_val("rst_exc", exc_v_o, 1'b0);
    check_val("rst_cap", capture_v_o, 1'b0);
    compare_all();
    v_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("rst_lost", v_o, 1'b0);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      rand_req();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_be_mem_fault_pipe.md
BP_BE_MEM_FAULT_PIPE -- requirements
Module: bp_be_mem_fault_pipe

Interface
REQ-001 The block SHALL have parameter vaddr_width_p, default 39, virtual address width.
REQ-002 The block SHALL have parameter eaddr_width_p, default 64, effective address width (> vaddr_width_p).
REQ-003 The block SHALL have parameter stages_p, default 2, pipeline depth (>= 1).
REQ-004 The block SHALL have ports clk_i in 1 (clock) and reset_n_i in 1 (reset: one clock; reset is asynchronous and active-low).
REQ-005 The block SHALL have ports flush_i in 1 (kill in-flight) and stall_i in 1 (hold all stages).
REQ-006 The block SHALL have request ports v_i in 1, store_i in 1, size_i in 2 (0=B,1=H,2=W,3=D), and eaddr_i in eaddr_width_p.
REQ-007 The block SHALL have context ports translation_en_i in 1, priv_mode_i in 2, and mstatus_sum_i in 1.
REQ-008 The block SHALL have TLB/PMA result ports tlb_v_i in 1, tlb_u_i in 1, tlb_w_i in 1, tlb_d_i in 1, and access_fault_i in 1.
REQ-009 The block SHALL have outputs v_o out 1, vaddr_o out vaddr_width_p, exc_v_o out 1, exc_cause_o out 4, and tlb_miss_v_o out 1.
REQ-010 The block SHALL have capture ports capture_v_o out 1, capture_cause_o out 4, capture_vaddr_o out vaddr_width_p, and capture_clr_i in 1.

Function
REQ-011 The block SHALL evaluate faults combinationally on stage-0 inputs and register results into stage 1.
REQ-012 Results SHALL appear at the outputs exactly stages_p cycles after acceptance, excluding stall cycles.
REQ-013 A request with eaddr_i[eaddr_width_p-1:vaddr_width_p] not equal to the sign-extension of bit vaddr_width_p-1 SHALL be non-canonical.
REQ-014 Misaligned SHALL mean: H with addr[0] set; W with addr[1:0] nonzero; D with addr[2:0] nonzero.
REQ-015 Page fault SHALL require translation_en_i and tlb_v_i, plus either a privilege fault (S mode, ~sum, u=1; or U mode, u=0) or (store and (~w or ~d)).
REQ-016 A non-canonical address SHALL be reported as a page fault when translation_en_i=1, and as an access fault otherwise.
REQ-017 Access fault SHALL be access_fault_i when tlb_v_i=1 or translation_en_i=0.
REQ-018 Cause priority SHALL be misaligned > page > access, with causes 4/6 misaligned, 13/15 page, 5/7 access (load/store).
REQ-019 tlb_miss_v_o SHALL equal translation_en_i & ~tlb_v_i & no misaligned & canonical; a miss SHALL never raise exc_v_o.
REQ-020 vaddr_o SHALL equal eaddr_i[vaddr_width_p-1:0] of the same request.
REQ-021 When stall_i=1, all stage registers SHALL hold, and v_i SHALL be ignored.
REQ-022 When flush_i=1, all stage valid bits SHALL clear on the next edge, and the same-cycle v_i SHALL be dropped; flush SHALL dominate stall.
REQ-023 When exc_v_o=1, v_o=1, and capture_v_o=0, the capture register SHALL load cause and vaddr, and capture_v_o SHALL be set.
REQ-024 While capture_v_o=1, later faults SHALL NOT overwrite the capture register.
REQ-025 capture_clr_i SHALL clear capture_v_o next cycle; a new fault in the same cycle as capture_clr_i SHALL win and load.
REQ-026 exc_v_o, tlb_miss_v_o, and exc_cause_o SHALL be zero whenever v_o=0.

Reset
REQ-027 On reset_n_i low, all stage valid bits, v_o, exc_v_o, tlb_miss_v_o, and capture_v_o SHALL be 0, and exc_cause_o, capture_cause_o, vaddr_o, and capture_vaddr_o SHALL be 0, asynchronously.
REQ-028 A request in flight at reset assertion SHALL be lost and never reported.

Configuration
REQ-029 The block SHALL support macro BP_BE_MISALIGNED_TRAP_EN.
REQ-030 When BP_BE_MISALIGNED_TRAP_EN is defined, misaligned detection SHALL operate per REQ-014.
REQ-031 When BP_BE_MISALIGNED_TRAP_EN is undefined, misaligned SHALL be constant 0, causes 4/6 SHALL never be produced, and priority SHALL be page > access.

Structure
REQ-032 The mem-exception cause enum (4,5,6,7,13,15) and the size enum SHALL live in bp_be_pkg.
REQ-033 One sub-module, bp_be_mem_fault_capture, SHALL hold the first-fault capture register.
REQ-034 Stage registers SHALL be a stages_p-deep parametrised array.

Verification
REQ-035 Verify: U mode, translation on, tlb_v=1, u=1, load D at 0x1000 -> v_o at cycle +2, exc_v_o=0, vaddr_o=0x1000.
REQ-036 Verify: store W at 0x1002 with MISALIGNED_TRAP_EN defined -> exc_cause_o=6; with the macro undefined -> exc_v_o=0.
REQ-037 Verify: translation on, eaddr=0x0000_0080_0000_0000 (non-canonical, vaddr 39) load -> cause 13; translation off -> cause 5.
REQ-038 Verify: store, S mode, w=1, d=0 -> cause 15; the same request with access_fault_i=1 also -> 15 (priority).
REQ-039 Verify: two faulting loads back-to-back -> capture holds the first vaddr; capture_clr_i together with the third fault -> capture loads the third.
REQ-040 Verify: request accepted, then flush_i asserted with stall_i=1 -> no v_o ever; reset_n_i pulsed mid-flight -> all outputs 0 immediately.
